// File: rtl/clk_freq_meter.sv
// clk_freq_meter
// Measures the frequency of an asynchronous or divided clock. sig_in is handled
// as a data signal sampled in the clk_in domain. The meter counts its rising
// edges over a gate window of GATE_CYCLES system clocks and reports the result.
//
// Ports:
//   clk_in   : system/reference clock, all logic on the rising edge
//   rst      : synchronous, active-high reset
//   start    : one-cycle request to begin a measurement (only honoured in IDLE)
//   cont     : continuous mode, sampled in the DONE cycle
//   sig_in   : asynchronous signal being measured
//   busy     : high while a gate is open or its result is being presented
//   done     : one-cycle pulse; count/overflow/dead are valid from this cycle
//   count    : rising edges seen in the last gate (saturates at all-ones)
//   overflow : last gate had more edges than count can hold
//   dead     : last gate saw no edges at all
module clk_freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             sig_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             dead
);

    localparam int TMR_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;
    logic                   rise_p1;
    logic [TMR_W-1:0]       timer;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   ovf_sticky;
    logic                   gate_clr;
    logic                   gate_last;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic inc);
        if (inc && (c != {CNT_W{1'b1}}))
            return c + CNT_W'(1);
        else
            return c;
    endfunction

    // True when an increment is attempted on a counter that is already full.
    function automatic logic sat_hit(input logic [CNT_W-1:0] c, input logic inc);
        return inc && (c == {CNT_W{1'b1}});
    endfunction

    // Stage p0: synchronizer chain; stage p1: previous-value flop for edge detect
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_p0 <= '0;
            prev_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
            prev_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign rise_p1   = sync_p0[SYNC_STAGES-1] & ~prev_p1;
    assign gate_last = (timer == TMR_LAST);

    always_ff @(posedge clk_in) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gate_clr  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = GATE;
                    gate_clr  = 1'b1;
                end
            end
            GATE: begin
                busy = 1'b1;
                if (gate_last)
                    state_nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                // start arriving here is dropped; only cont can re-open a gate
                if (cont) begin
                    state_nxt = GATE;
                    gate_clr  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate timer, edge counter and result registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            timer      <= '0;
            edge_cnt   <= '0;
            ovf_sticky <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
            dead       <= 1'b0;
        end else begin
            if (gate_clr) begin
                timer      <= '0;
                edge_cnt   <= '0;
                ovf_sticky <= 1'b0;
            end else if (state == GATE) begin
                timer      <= timer + TMR_W'(1);
                edge_cnt   <= sat_inc(edge_cnt, rise_p1);
                ovf_sticky <= ovf_sticky | sat_hit(edge_cnt, rise_p1);
            end
            // Results include an edge landing in the final gate cycle, so
            // they come from the counter's next value, not its current one.
            if ((state == GATE) && gate_last) begin
                count    <= sat_inc(edge_cnt, rise_p1);
                overflow <= ovf_sticky | sat_hit(edge_cnt, rise_p1);
                dead     <= (edge_cnt == '0) && !rise_p1;
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
`timescale 1ns/1ps
// Testbench for clk_freq_meter: one instance with default parameters and a
// narrow-counter instance (CNT_W=8, GATE_CYCLES=1100) for saturation.
module tb_clk_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cont, start8, cont8;
    logic        sig_in;
    logic        busy, done, overflow, dead;
    logic [15:0] count;
    logic        busy8, done8, overflow8, dead8;
    logic [7:0]  count8;

    logic        sig_div4 = 1'b0;
    logic        sig_fast = 1'b0;
    int          mode;

    typedef struct {
        int lo;
        int hi;
        bit ovf;
        bit dd;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #10 clk = ~clk;

    // clk/4 stimulus, moved off the clock edge
    initial forever begin
        repeat (2) @(posedge clk);
        #5 sig_div4 = ~sig_div4;
    end

    // Asynchronous stimulus with a 40.67 ns period
    initial forever #20.335 sig_fast = ~sig_fast;

    assign sig_in = (mode == 0) ? 1'b0 :
                    (mode == 1) ? 1'b1 :
                    (mode == 2) ? sig_div4 : sig_fast;

    clk_freq_meter #(.GATE_CYCLES(1000), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk_in(clk), .rst(rst), .start(start), .cont(cont), .sig_in(sig_in),
        .busy(busy), .done(done), .count(count), .overflow(overflow), .dead(dead)
    );

    clk_freq_meter #(.GATE_CYCLES(1100), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk_in(clk), .rst(rst), .start(start8), .cont(cont8), .sig_in(sig_div4),
        .busy(busy8), .done(done8), .count(count8), .overflow(overflow8), .dead(dead8)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Counts rising edges until done is seen (sampled 1 ns after the edge).
    task automatic wait_done(input bit sel, input int budget, output int n, output bit got);
        got = 1'b0;
        n   = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if ((sel ? done8 : done) === 1'b1) begin
                n   = i;
                got = 1'b1;
                break;
            end
        end
    endtask

    // Pops the oldest expectation and compares it with the current outputs.
    task automatic compare(input string tag, input bit sel, input int lat, input bit got);
        exp_t e;
        e = sb.pop_front();
        check({tag, "_done_seen"}, int'(got), 1);
        if (got) begin
            check({tag, "_latency"}, lat, e.lat);
            check_range({tag, "_count"}, sel ? int'(count8) : int'(count), e.lo, e.hi);
            check({tag, "_overflow"}, int'(sel ? overflow8 : overflow), int'(e.ovf));
            check({tag, "_dead"}, int'(sel ? dead8 : dead), int'(e.dd));
            check({tag, "_busy_at_done"}, int'(sel ? busy8 : busy), 1);
        end
    endtask

    // One-shot measurement; latency is counted from the cycle start is high.
    task automatic measure(input string tag, input bit sel, input int budget);
        int n;
        bit got;
        @(posedge clk); #1;
        if (sel) start8 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        start  = 1'b0;
        wait_done(sel, budget, n, got);
        compare(tag, sel, n + 1, got);
    endtask

    initial begin
        int  n;
        bit  got;
        rst    = 1'b1;
        start  = 1'b0;
        cont   = 1'b0;
        start8 = 1'b0;
        cont8  = 1'b0;
        mode   = 2;

        repeat (3) @(posedge clk); #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_dead", int'(dead), 0);
        check("rst_busy8", int'(busy8), 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);

        // clk/4 input: about 250 edges per 1000-cycle gate
        sb.push_back('{lo: 249, hi: 251, ovf: 1'b0, dd: 1'b0, lat: 1001});
        measure("div4", 1'b0, 1200);

        // Static input, low then high: no edges
        mode = 0;
        repeat (8) @(posedge clk);
        sb.push_back('{lo: 0, hi: 0, ovf: 1'b0, dd: 1'b1, lat: 1001});
        measure("hold0", 1'b0, 1200);
        mode = 1;
        repeat (8) @(posedge clk);
        sb.push_back('{lo: 0, hi: 0, ovf: 1'b0, dd: 1'b1, lat: 1001});
        measure("hold1", 1'b0, 1200);

        // Asynchronous 40.67 ns input: 20000 / 40.67 = 491.8 edges
        mode = 3;
        repeat (8) @(posedge clk);
        sb.push_back('{lo: 491, hi: 493, ovf: 1'b0, dd: 1'b0, lat: 1001});
        measure("async", 1'b0, 1200);

        // 8-bit counter over 1100 cycles of clk/4 (~275 edges) saturates
        sb.push_back('{lo: 255, hi: 255, ovf: 1'b1, dd: 1'b0, lat: 1101});
        measure("sat8", 1'b1, 1300);

        // Continuous mode
        mode = 2;
        repeat (8) @(posedge clk); #1;
        cont = 1'b1;
        sb.push_back('{lo: 249, hi: 251, ovf: 1'b0, dd: 1'b0, lat: 1001});
        measure("cont0", 1'b0, 1200);
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{lo: 249, hi: 251, ovf: 1'b0, dd: 1'b0, lat: 1001});
            repeat (100) @(posedge clk); #1;
            // start while busy must not add a done; on the last lap cont drops
            start = 1'b1;
            if (k == 2) cont = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(1'b0, 1200, n, got);
            compare($sformatf("cont%0d", k + 1), 1'b0, n + 101, got);
        end
        // start coinciding with DONE while cont=0 is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_after_cont", int'(busy), 0);
        wait_done(1'b0, 1100, n, got);
        check("no_extra_done", int'(got), 0);

        // Reset in the middle of a gate aborts it
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (500) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_dead", int'(dead), 0);
        check("midrst_overflow8", int'(overflow8), 0);
        rst = 1'b0;
        wait_done(1'b0, 1100, n, got);
        check("midrst_no_done", int'(got), 0);
        sb.push_back('{lo: 249, hi: 251, ovf: 1'b0, dd: 1'b0, lat: 1001});
        measure("after_rst", 1'b0, 1200);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
